sketch_bitmap_gen: RTL and testbench

//  Parametrised etch-a-sketch bitmap generator, next generation of the single-size sketch pad.

---
 rtl/sketch_bitmap_gen_if.sv | 43 ++++
 rtl/sketch_bitmap_gen.sv | 250 +++++++++++++++++++++++++
 tb/tb_sketch_bitmap_gen.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sketch_bitmap_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : sketch_bitmap_gen_if
// Description : Bundles the video, control and status signals of the sketch
//               bitmap generator. master = the driving side (sync/controls),
//               slave = the generator itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface sketch_bitmap_gen_if #(
    parameter int XW = 7,
    parameter int YW = 7,
    parameter int CW = 3
);
    logic          video_on;
    logic [9:0]    pix_x;
    logic [9:0]    pix_y;
    logic          dir_up;
    logic          dir_down;
    logic          dir_left;
    logic          dir_right;
    logic          pen_down;
    logic [CW-1:0] pen_rgb;
    logic          clr_req;
    logic [CW-1:0] bit_rgb;
    logic          busy;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;

    modport master (
        output video_on, pix_x, pix_y,
        output dir_up, dir_down, dir_left, dir_right,
        output pen_down, pen_rgb, clr_req,
        input  bit_rgb, busy, cur_x, cur_y
    );

    modport slave (
        input  video_on, pix_x, pix_y,
        input  dir_up, dir_down, dir_left, dir_right,
        input  pen_down, pen_rgb, clr_req,
        output bit_rgb, busy, cur_x, cur_y
    );
endinterface
`default_nettype wire

// File: rtl/sketch_bitmap_gen.sv
`default_nettype none
// ============================================================================
// Module      : sketch_bitmap_gen
// Description : Etch-a-sketch bitmap generator. Frame buffer in a dual-port
//               RAM, pen cursor driven by direction levels with auto-repeat,
//               clear sweep, and a 2-cycle pixel read path with a blinking
//               cursor overlay at a configurable screen origin.
// Revision    : 1.0 - initial release
// ============================================================================
module sketch_bitmap_gen #(
    parameter int            XW         = 7,
    parameter int            YW         = 7,
    parameter int            CW         = 3,
    parameter logic [9:0]    ORG_X      = 10'd0,
    parameter logic [9:0]    ORG_Y      = 10'd0,
    parameter logic [CW-1:0] BORDER_RGB = CW'(3'b110),
    parameter logic [CW-1:0] CLR_RGB    = CW'(3'b000),
    parameter bit            WRAP       = 1'b1,
    parameter int            REPEAT_DLY = 5000000,
    parameter int            REPEAT_PER = 1000000,
    parameter int            BLINK_DIV  = 12500000
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    sketch_bitmap_gen_if.slave bus
);
    localparam int AW    = XW + YW;
    localparam int DEPTH = 1 << AW;
    localparam int RMAX  = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int CNT_W = $clog2(RMAX + 1);
    localparam int BLK_W = $clog2(BLINK_DIV + 1);
    localparam logic [10:0]    BMP_W  = 11'(1) << XW;
    localparam logic [10:0]    BMP_H  = 11'(1) << YW;
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PER - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t           state;
    logic [AW-1:0]    clr_addr;
    logic             busy_r;

    logic [XW-1:0]    cur_x;
    logic [YW-1:0]    cur_y;
    logic [XW-1:0]    nxt_x;
    logic [YW-1:0]    nxt_y;

    logic [3:0]       dir_vec;
    logic [3:0]       dir_prev;
    logic [CNT_W-1:0] rpt_cnt;
    logic             rpt_mode;
    logic             step;

    logic [BLK_W-1:0] blink_cnt;
    logic             blink;

    logic             we;
    logic [AW-1:0]    waddr;
    logic [CW-1:0]    wdata;
    logic [CW-1:0]    mem [DEPTH];
    logic [CW-1:0]    dout;

    logic [9:0]       rel_x;
    logic [9:0]       rel_y;
    logic             in_bmp;
    logic             hit;
    logic [AW-1:0]    raddr;
    logic             vid_d;
    logic             bmp_d;
    logic             hit_d;
    logic [CW-1:0]    bit_rgb;

    // Clear-sweep / idle controller; the sweep cannot be restarted while running
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
            busy_r   <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == {AW{1'b1}}) begin
                        state  <= ST_IDLE;
                        busy_r <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (bus.clr_req) begin
                        state    <= ST_CLEAR;
                        clr_addr <= '0;
                        busy_r   <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

    // Write port mux: the sweep owns the port, the pen only writes when idle
    always_comb begin
        we    = 1'b0;
        waddr = clr_addr;
        wdata = CLR_RGB;
        if (state == ST_CLEAR) begin
            we = 1'b1;
        end else if (bus.pen_down) begin
            we    = 1'b1;
            waddr = {cur_y, cur_x};
            wdata = bus.pen_rgb;
        end
    end

    assign dir_vec = {bus.dir_up, bus.dir_down, bus.dir_left, bus.dir_right};

    // Step on a new nonzero direction, then after the initial hold delay, then periodically
    always_comb begin
        step = 1'b0;
        if (dir_vec != 4'b0000) begin
            if (dir_vec != dir_prev) begin
                step = 1'b1;
            end else if (!rpt_mode) begin
                step = (rpt_cnt == DLY_LAST);
            end else begin
                step = (rpt_cnt == PER_LAST);
            end
        end
    end

    // Auto-repeat timer; restarts whenever the direction vector changes or drops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_prev <= 4'b0000;
            rpt_cnt  <= '0;
            rpt_mode <= 1'b0;
        end else begin
            dir_prev <= dir_vec;
            if ((dir_vec == 4'b0000) || (dir_vec != dir_prev)) begin
                rpt_cnt  <= '0;
                rpt_mode <= 1'b0;
            end else if (step) begin
                rpt_cnt  <= '0;
                rpt_mode <= 1'b1;
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end
    end

    // Opposing directions cancel per axis; edge behaviour chosen at elaboration
    generate
        if (WRAP) begin : g_wrap
            always_comb begin
                nxt_x = cur_x;
                nxt_y = cur_y;
                if (bus.dir_right && !bus.dir_left) nxt_x = cur_x + 1'b1;
                if (bus.dir_left && !bus.dir_right) nxt_x = cur_x - 1'b1;
                if (bus.dir_down && !bus.dir_up)    nxt_y = cur_y + 1'b1;
                if (bus.dir_up && !bus.dir_down)    nxt_y = cur_y - 1'b1;
            end
        end else begin : g_clamp
            always_comb begin
                nxt_x = cur_x;
                nxt_y = cur_y;
                if (bus.dir_right && !bus.dir_left && (cur_x != {XW{1'b1}})) nxt_x = cur_x + 1'b1;
                if (bus.dir_left && !bus.dir_right && (cur_x != '0))         nxt_x = cur_x - 1'b1;
                if (bus.dir_down && !bus.dir_up && (cur_y != {YW{1'b1}}))    nxt_y = cur_y + 1'b1;
                if (bus.dir_up && !bus.dir_down && (cur_y != '0))            nxt_y = cur_y - 1'b1;
            end
        end
    endgenerate

    // Cursor register; moves are allowed even during the clear sweep
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_x <= '0;
            cur_y <= '0;
        end else if (step) begin
            cur_x <= nxt_x;
            cur_y <= nxt_y;
        end
    end

    // Cursor blink phase generator
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (blink_cnt == BLK_LAST) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Screen-to-bitmap mapping; the >= tests guard against 10-bit wrap of the subtraction
    always_comb begin
        rel_x  = bus.pix_x - ORG_X;
        rel_y  = bus.pix_y - ORG_Y;
        in_bmp = (bus.pix_x >= ORG_X) && ({1'b0, rel_x} < BMP_W) &&
                 (bus.pix_y >= ORG_Y) && ({1'b0, rel_y} < BMP_H);
        raddr  = {rel_y[YW-1:0], rel_x[XW-1:0]};
        hit    = in_bmp && (rel_x[XW-1:0] == cur_x) && (rel_y[YW-1:0] == cur_y);
    end

    // Frame buffer: read-before-write so a same-address read sees old data
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        dout <= mem[raddr];
    end

    // Pixel pipeline: align qualifiers with RAM data, then register the colour
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vid_d   <= 1'b0;
            bmp_d   <= 1'b0;
            hit_d   <= 1'b0;
            bit_rgb <= '0;
        end else begin
            vid_d <= bus.video_on;
            bmp_d <= in_bmp;
            hit_d <= hit;
            if (!vid_d) begin
                bit_rgb <= '0;
            end else if (!bmp_d) begin
                bit_rgb <= BORDER_RGB;
            end else if (hit_d && blink) begin
                bit_rgb <= ~dout;
            end else begin
                bit_rgb <= dout;
            end
        end
    end

    assign bus.bit_rgb = bit_rgb;
    assign bus.busy    = busy_r;
    assign bus.cur_x   = cur_x;
    assign bus.cur_y   = cur_y;

endmodule
`default_nettype wire

// File: tb/tb_sketch_bitmap_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sketch_bitmap_gen
// Description : Self-checking bench for sketch_bitmap_gen (wrap and clamp
//               instances), directed steps plus randomized taps, pen writes
//               and pixel reads against a frame/cursor/blink model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sketch_bitmap_gen;
    localparam int       XW = 3;
    localparam int       YW = 3;
    localparam int       CW = 3;
    localparam int       BD = 8;
    localparam int       OX = 16;
    localparam int       OY = 8;
    localparam logic [2:0] BORDER = 3'b110;
    localparam logic [2:0] CLRC   = 3'b000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   edges = 0;
    int   total = 0;
    int   passed = 0;

    logic [2:0] mem_m [64];
    int mx = 0;
    int my = 0;

    always #5 clk = ~clk;

    sketch_bitmap_gen_if #(.XW(XW), .YW(YW), .CW(CW)) bw ();
    sketch_bitmap_gen_if #(.XW(XW), .YW(YW), .CW(CW)) bc ();

    sketch_bitmap_gen #(
        .XW(XW), .YW(YW), .CW(CW), .ORG_X(10'd16), .ORG_Y(10'd8),
        .BORDER_RGB(3'b110), .CLR_RGB(3'b000), .WRAP(1'b1),
        .REPEAT_DLY(10), .REPEAT_PER(4), .BLINK_DIV(8)
    ) u_wrap (.clk(clk), .reset_n(reset_n), .bus(bw));

    sketch_bitmap_gen #(
        .XW(XW), .YW(YW), .CW(CW), .ORG_X(10'd16), .ORG_Y(10'd8),
        .BORDER_RGB(3'b110), .CLR_RGB(3'b000), .WRAP(1'b0),
        .REPEAT_DLY(10), .REPEAT_PER(4), .BLINK_DIV(8)
    ) u_clamp (.clk(clk), .reset_n(reset_n), .bus(bc));

    // clock edges seen since reset release; blink phase = (edges / BD) % 2
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edges <= 0;
        else          edges <= edges + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [2:0] exp_pix(input int px, input int py, input bit vid, input int blk);
        logic [2:0] c;
        if (!vid) return 3'b000;
        if (px < OX || px >= OX + 8 || py < OY || py >= OY + 8) return BORDER;
        c = mem_m[(py - OY) * 8 + (px - OX)];
        if ((px - OX) == mx && (py - OY) == my && blk != 0) c = ~c;
        return c;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 64; i++) mem_m[i] = CLRC;
    endtask

    // entered and left at a falling edge
    task automatic check_pix(input int px, input int py, input bit vid);
        logic [2:0] e;
        bw.pix_x = 10'(px);
        bw.pix_y = 10'(py);
        bw.video_on = vid;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        e = exp_pix(px, py, vid, ((edges - 1) / BD) % 2);
        check("pixel", 32'(bw.bit_rgb), 32'(e));
    endtask

    task automatic tap(input logic [3:0] d);
        {bw.dir_up, bw.dir_down, bw.dir_left, bw.dir_right} = d;
        @(negedge clk);
        {bw.dir_up, bw.dir_down, bw.dir_left, bw.dir_right} = 4'b0000;
        @(negedge clk);
        if (d[0] && !d[1]) mx = (mx + 1) % 8;
        if (d[1] && !d[0]) mx = (mx + 7) % 8;
        if (d[2] && !d[3]) my = (my + 1) % 8;
        if (d[3] && !d[2]) my = (my + 7) % 8;
    endtask

    task automatic tap_c(input logic [3:0] d);
        {bc.dir_up, bc.dir_down, bc.dir_left, bc.dir_right} = d;
        @(negedge clk);
        {bc.dir_up, bc.dir_down, bc.dir_left, bc.dir_right} = 4'b0000;
        @(negedge clk);
    endtask

    task automatic pen(input logic [2:0] c);
        bw.pen_down = 1'b1;
        bw.pen_rgb  = c;
        @(negedge clk);
        bw.pen_down = 1'b0;
        mem_m[my * 8 + mx] = c;
    endtask

    // counts falling edges with busy high; also pokes clr_req mid-sweep
    task automatic count_busy(input int pen_from, input int pen_to, input int move_at, output int n);
        n = 0;
        while (bw.busy === 1'b1 && n < 200) begin
            bw.pen_down  = (n >= pen_from && n < pen_to);
            bw.pen_rgb   = 3'b111;
            bw.dir_right = (n == move_at);
            bw.clr_req   = (n == 20);
            n++;
            @(negedge clk);
        end
        bw.pen_down  = 1'b0;
        bw.dir_right = 1'b0;
        bw.clr_req   = 1'b0;
    endtask

    initial begin
        int n;
        int ex;
        logic [3:0] d;
        bw.video_on = 0; bw.pix_x = '0; bw.pix_y = '0;
        bw.dir_up = 0; bw.dir_down = 0; bw.dir_left = 0; bw.dir_right = 0;
        bw.pen_down = 0; bw.pen_rgb = '0; bw.clr_req = 0;
        bc.video_on = 0; bc.pix_x = '0; bc.pix_y = '0;
        bc.dir_up = 0; bc.dir_down = 0; bc.dir_left = 0; bc.dir_right = 0;
        bc.pen_down = 0; bc.pen_rgb = '0; bc.clr_req = 0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_busy", 32'(bw.busy), 32'd1);
        check("rst_cur_x", 32'(bw.cur_x), 32'd0);
        check("rst_cur_y", 32'(bw.cur_y), 32'd0);
        check("rst_bit_rgb", 32'(bw.bit_rgb), 32'd0);

        // sweep after reset; pen held during part of it must not land
        reset_n = 1'b1;
        count_busy(30, 60, -1, n);
        check("sweep_len_reset", 32'(n), 32'd64);
        check("clamp_idle", 32'(bc.busy), 32'd0);
        clear_model();
        mx = 0; my = 0;

        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                check_pix(OX + x, OY + y, 1'b1);
        check_pix(5, 5, 1'b1);
        check_pix(18, 9, 1'b0);
        check("clamp_video_off", 32'(bc.bit_rgb), 32'd0);

        // hold right 30 cycles: steps at cycles 0,10,14,18,22,26
        bw.dir_right = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            ex = 1 + ((k >= 10) ? 1 + (k - 10) / 4 : 0);
            check("hold_right", 32'(bw.cur_x), 32'(ex));
        end
        bw.dir_right = 1'b0;
        mx = 6;
        @(negedge clk);

        bw.dir_up = 1'b1; bw.dir_down = 1'b1;
        repeat (12) @(negedge clk);
        check("up_down_y", 32'(bw.cur_y), 32'd0);
        check("up_down_x", 32'(bw.cur_x), 32'd6);
        bw.dir_up = 1'b0; bw.dir_down = 1'b0;
        @(negedge clk);

        tap(4'b0001);
        check("wrap_to_7", 32'(bw.cur_x), 32'd7);
        tap(4'b0001);
        check("wrap_to_0", 32'(bw.cur_x), 32'd0);
        tap(4'b1000);
        check("wrap_y_7", 32'(bw.cur_y), 32'd7);
        tap(4'b0100);
        check("wrap_y_0", 32'(bw.cur_y), 32'd0);

        tap_c(4'b0010);
        check("clamp_left", 32'(bc.cur_x), 32'd0);
        tap_c(4'b1000);
        check("clamp_up", 32'(bc.cur_y), 32'd0);
        for (int k = 0; k < 9; k++) tap_c(4'b0001);
        check("clamp_right", 32'(bc.cur_x), 32'd7);
        tap_c(4'b0010);
        check("clamp_back", 32'(bc.cur_x), 32'd6);

        // pen at (2,1), read back across both blink phases
        tap(4'b0001);
        tap(4'b0001);
        tap(4'b0100);
        check("pen_pos_x", 32'(bw.cur_x), 32'd2);
        check("pen_pos_y", 32'(bw.cur_y), 32'd1);
        pen(3'b101);
        for (int k = 0; k < 6; k++) check_pix(18, 9, 1'b1);
        tap(4'b0001);
        check_pix(18, 9, 1'b1);
        check_pix(19, 9, 1'b1);

        // randomized taps and pen strokes, then random screen reads
        for (int i = 0; i < 24; i++) begin
            d = 4'($urandom_range(1, 15));
            tap(d);
            check("rand_cur_x", 32'(bw.cur_x), 32'(mx));
            check("rand_cur_y", 32'(bw.cur_y), 32'(my));
            if ($urandom_range(0, 1) == 1) pen(3'($urandom_range(0, 7)));
        end
        for (int i = 0; i < 30; i++)
            check_pix($urandom_range(10, 30), $urandom_range(4, 20), $urandom_range(0, 7) != 0);

        // clear request from idle
        bw.clr_req = 1'b1;
        @(negedge clk);
        bw.clr_req = 1'b0;
        count_busy(-1, -1, -1, n);
        check("sweep_len_req", 32'(n), 32'd64);
        clear_model();
        for (int i = 0; i < 8; i++)
            check_pix(OX + $urandom_range(0, 7), OY + $urandom_range(0, 7), 1'b1);

        // reset in the middle of a sweep, cursor moved during the fresh sweep
        if (mx == 0) tap(4'b0001);
        bw.clr_req = 1'b1;
        @(negedge clk);
        bw.clr_req = 1'b0;
        repeat (25) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_cur_x", 32'(bw.cur_x), 32'd0);
        check("midrst_cur_y", 32'(bw.cur_y), 32'd0);
        check("midrst_busy", 32'(bw.busy), 32'd1);
        reset_n = 1'b1;
        count_busy(-1, -1, 10, n);
        check("sweep_len_midrst", 32'(n), 32'd64);
        mx = 1; my = 0;
        check("move_in_clear", 32'(bw.cur_x), 32'd1);
        clear_model();
        for (int i = 0; i < 16; i++)
            check_pix(OX + $urandom_range(0, 7), OY + $urandom_range(0, 7), 1'b1);
        check_pix(17, 8, 1'b1);
        check_pix(17, 8, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
